ram32_bist: RTL and testbench

//  Built-in self-test initiator for a ram32 instance. Drives the RAM's addr/din/bwe/ren port and checks dout.

---
 rtl/ram32_bist.sv | 237 +++++++++++++++++++++++
 tb/tb_ram32_bist.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram32_bist.sv
`default_nettype none
// ============================================================================
//  Module   : ram32_bist
//  Purpose  : Built-in self-test initiator for a ram32 word memory. Runs a
//             full-word write, read-compare, single-byte-lane write and
//             read-compare sweep, and reports pass/fail together with the
//             first failing location.
//  Revision : 1.0 - initial release
// ============================================================================
module ram32_bist #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] SEED       = 32'hA5C3_0F96
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-3:0] fail_addr,
    output logic                  fail_phase,
    output logic [31:0]           fail_data,
    output logic [31:0]           fail_exp,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_bwe,
    output logic                  mem_ren,
    input  logic [31:0]           mem_dout
);

    localparam int AW = ADDR_WIDTH - 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_R1   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [AW-1:0] c_addr_last = '1;
    localparam logic [AW-1:0] c_addr_one  = {{(AW-1){1'b0}}, 1'b1};

    // Base pattern: seed XOR zero-extended word address.
    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        pat = SEED ^ 32'(a);
    endfunction

    // Byte lane exercised by the partial-write pass is the address low bits.
    function automatic logic [1:0] lane(input logic [AW-1:0] a);
        logic [31:0] ext;
        ext  = 32'(a);
        lane = ext[1:0];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [AW-1:0] a);
        lane_mask = 32'h0000_00FF << {lane(a), 3'b000};
    endfunction

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tail_q, tail_d;          // compare-only last cycle of a read pass
    logic          cmp_valid_q, cmp_valid_d; // a read was issued last cycle
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic          fail_phase_q, fail_phase_d;
    logic [31:0]   fail_data_q, fail_data_d;
    logic [31:0]   fail_exp_q, fail_exp_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_din_q, mem_din_d;
    logic [3:0]    mem_bwe_q, mem_bwe_d;
    logic          mem_ren_q, mem_ren_d;

    logic          w_in_read;
    logic [31:0]   w_exp;
    logic          w_mismatch;

    // Expected read data for the word read last cycle, and the compare result.
    always_comb begin
        w_in_read  = (state_q == S_R0) || (state_q == S_R1);
        w_exp      = (state_q == S_R1) ? (pat(cmp_addr_q) ^ lane_mask(cmp_addr_q))
                                       : pat(cmp_addr_q);
        w_mismatch = w_in_read && cmp_valid_q && (mem_dout != w_exp);
    end

    // Sequencer: phase progression, address stepping and first-fail capture.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tail_d       = tail_q;
        cmp_valid_d  = cmp_valid_q;
        cmp_addr_d   = cmp_addr_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_phase_d = fail_phase_q;
        fail_data_d  = fail_data_q;
        fail_exp_d   = fail_exp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_W0;
                    addr_d       = '0;
                    tail_d       = 1'b0;
                    cmp_valid_d  = 1'b0;
                    cmp_addr_d   = '0;
                    pass_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_phase_d = 1'b0;
                    fail_data_d  = '0;
                    fail_exp_d   = '0;
                end
            end
            S_W0, S_W1: begin
                if (addr_q == c_addr_last) begin
                    state_d     = (state_q == S_W0) ? S_R0 : S_R1;
                    addr_d      = '0;
                    tail_d      = 1'b0;
                    cmp_valid_d = 1'b0;
                end else begin
                    addr_d = addr_q + c_addr_one;
                end
            end
            S_R0, S_R1: begin
                if (w_mismatch) begin
                    state_d      = S_DONE;
                    pass_d       = 1'b0;
                    fail_addr_d  = cmp_addr_q;
                    fail_phase_d = (state_q == S_R1);
                    fail_data_d  = mem_dout;
                    fail_exp_d   = w_exp;
                    cmp_valid_d  = 1'b0;
                    tail_d       = 1'b0;
                end else if (tail_q) begin
                    state_d     = (state_q == S_R0) ? S_W1 : S_DONE;
                    pass_d      = (state_q == S_R1);
                    addr_d      = '0;
                    tail_d      = 1'b0;
                    cmp_valid_d = 1'b0;
                end else begin
                    cmp_valid_d = 1'b1;
                    cmp_addr_d  = addr_q;
                    // Hold the address on the last word; the extra cycle only compares.
                    if (addr_q == c_addr_last) begin
                        tail_d = 1'b1;
                    end else begin
                        addr_d = addr_q + c_addr_one;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        busy_d    = (state_d == S_W0) || (state_d == S_R0) ||
                    (state_d == S_W1) || (state_d == S_R1);
        done_d    = (state_d == S_DONE);
        mem_addr_d = busy_d ? addr_d : '0;
        mem_din_d  = '0;
        mem_bwe_d  = 4'h0;
        mem_ren_d  = 1'b0;
        case (state_d)
            S_W0: begin
                mem_bwe_d = 4'hF;
                mem_din_d = pat(addr_d);
            end
            S_W1: begin
                mem_bwe_d = 4'b0001 << lane(addr_d);
                mem_din_d = ~pat(addr_d);
            end
            S_R0, S_R1: begin
                mem_ren_d = ~tail_d;
            end
            default: begin
                mem_din_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            tail_q       <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_phase_q <= 1'b0;
            fail_data_q  <= '0;
            fail_exp_q   <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_bwe_q    <= 4'h0;
            mem_ren_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tail_q       <= tail_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_addr_q  <= fail_addr_d;
            fail_phase_q <= fail_phase_d;
            fail_data_q  <= fail_data_d;
            fail_exp_q   <= fail_exp_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_bwe_q    <= mem_bwe_d;
            mem_ren_q    <= mem_ren_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_addr_q;
    assign fail_phase = fail_phase_q;
    assign fail_data  = fail_data_q;
    assign fail_exp   = fail_exp_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_bwe    = mem_bwe_q;
    assign mem_ren    = mem_ren_q;

endmodule
`default_nettype wire

// File: tb/tb_ram32_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram32_bist
//  Purpose  : Directed bench for ram32_bist with a behavioural ram32 model
//             that can inject a stuck bit or a dead byte lane.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram32_bist;

    localparam int          ADDR_WIDTH = 6;
    localparam int          N          = 16;
    localparam logic [31:0] SEED       = 32'hA5C3_0F96;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, pass, fail_phase, mem_ren;
    logic [3:0]  fail_addr, mem_addr;
    logic [31:0] fail_data, fail_exp, mem_din, mem_dout;
    logic [3:0]  mem_bwe;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural ram32 plus fault injection and a W1 snoop on word 5.
    logic [31:0] ram [0:N-1];
    logic        fault_stuck = 1'b0;   // word 9 bit 3 reads as 0
    logic        fault_lane2 = 1'b0;   // partial writes drop byte lane 2
    logic [3:0]  w1_bwe5 = 4'h0;
    logic [31:0] w1_din5 = 32'h0;

    ram32_bist #(.ADDR_WIDTH(ADDR_WIDTH), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_phase(fail_phase),
        .fail_data(fail_data), .fail_exp(fail_exp),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_bwe(mem_bwe),
        .mem_ren(mem_ren), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_bwe[k] && !(fault_lane2 && k == 2 && mem_bwe != 4'hF))
                ram[mem_addr][8*k +: 8] <= mem_din[8*k +: 8];
        end
        if (mem_ren)
            mem_dout <= (fault_stuck && mem_addr == 4'd9) ? (ram[mem_addr] & ~32'h8)
                                                          : ram[mem_addr];
        if (mem_addr == 4'd5 && mem_bwe != 4'h0 && mem_bwe != 4'hF) begin
            w1_bwe5 <= mem_bwe;
            w1_din5 <= mem_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // From a negedge just after start was sampled, count busy cycles until done.
    // mode 0: start low; mode 1: sparse start pulses; mode 2: start held high from cycle 10.
    task automatic wait_done(input int mode, output int bc, output int to_done);
        bc      = 0;
        to_done = 1;
        while (!done && to_done < 500) begin
            if (busy) bc++;
            if (mode == 1) start = (bc % 7 == 3);
            if (mode == 2 && bc >= 10) start = 1'b1;
            @(negedge clk);
            to_done++;
        end
        if (mode == 1) start = 1'b0;
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    int bc, td;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_status", {28'h0, busy, done, pass, fail_phase}, 32'h0);
        check("reset_mem", {23'h0, mem_ren, mem_bwe, mem_addr}, 32'h0);
        check("reset_din", mem_din, 32'h0);
        check("reset_fail", {28'h0, fail_addr} | fail_data | fail_exp, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Clean run: 4N+2 busy cycles, done on cycle 4N+3.
        pulse_start();
        wait_done(0, bc, td);
        check("clean_busy_cycles", bc, 32'd66);
        check("clean_done_cycle", td, 32'd67);
        check("clean_done_pass", {30'h0, done, pass}, 32'h3);
        check("clean_fail_addr", {28'h0, fail_addr}, 32'h0);
        check("clean_busy_low", {31'h0, busy}, 32'h0);
        // Partial write of word 5 uses lane 1.
        check("w1_bwe5", {28'h0, w1_bwe5}, 32'h2);
        check("w1_din5", w1_din5, ~(SEED ^ 32'h5));
        check("ram_word5", ram[5], (SEED ^ 32'h5) ^ 32'h0000_FF00);

        // P(9) has bit 3 set (0x96^0x09=0x9F), so a stuck-at-0 on that bit trips R0.
        fault_stuck = 1'b1;
        pulse_start();
        wait_done(0, bc, td);
        fault_stuck = 1'b0;
        check("stuck_busy_cycles", bc, 32'd27);
        check("stuck_pass", {30'h0, done, pass}, 32'h2);
        check("stuck_phase", {31'h0, fail_phase}, 32'h0);
        check("stuck_addr", {28'h0, fail_addr}, 32'h9);
        check("stuck_exp", fail_exp, SEED ^ 32'h9);
        check("stuck_data", fail_data, (SEED ^ 32'h9) ^ 32'h8);
        check("stuck_mem_idle", {27'h0, mem_ren, mem_bwe}, 32'h0);

        // Lane 2 never takes a partial write: first failure is word 2 in R1.
        fault_lane2 = 1'b1;
        pulse_start();
        wait_done(0, bc, td);
        fault_lane2 = 1'b0;
        check("lane2_busy_cycles", bc, 32'd53);
        check("lane2_pass", {30'h0, done, pass}, 32'h2);
        check("lane2_phase", {31'h0, fail_phase}, 32'h1);
        check("lane2_addr", {28'h0, fail_addr}, 32'h2);
        check("lane2_data", fail_data, 32'hA5C3_0F94);
        check("lane2_exp", fail_exp, 32'hA53C_0F94);

        // Reset during R0 at word 7 aborts to idle with all outputs cleared.
        pulse_start();
        td = 0;
        while (!(mem_ren && mem_addr == 4'd7) && td < 200) begin
            @(negedge clk);
            td++;
        end
        check("r0_addr7_reached", {31'h0, mem_ren}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_status", {28'h0, busy, done, pass, fail_phase}, 32'h0);
        check("abort_mem", {23'h0, mem_ren, mem_bwe, mem_addr} | mem_din, 32'h0);
        check("abort_fail", {28'h0, fail_addr} | fail_data | fail_exp, 32'h0);
        @(negedge clk);
        check("abort_stays_idle", {30'h0, busy, done}, 32'h0);
        pulse_start();
        wait_done(0, bc, td);
        check("after_abort_cycles", bc, 32'd66);
        check("after_abort_pass", {30'h0, done, pass}, 32'h3);

        // Start pulses while busy are ignored.
        pulse_start();
        wait_done(1, bc, td);
        check("pulses_busy_cycles", bc, 32'd66);
        check("pulses_pass", {30'h0, done, pass}, 32'h3);
        @(negedge clk);
        check("pulses_no_restart", {30'h0, busy, done}, 32'h1);

        // Start held high into DONE: first run unchanged, then restarts from DONE.
        pulse_start();
        wait_done(2, bc, td);
        check("held_busy_cycles", bc, 32'd66);
        @(negedge clk);
        start = 1'b0;
        check("held_restart", {30'h0, busy, done}, 32'h2);
        wait_done(0, bc, td);
        check("restart_busy_cycles", bc, 32'd66);
        check("restart_pass", {30'h0, done, pass}, 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
